spi_mem_bridge: RTL and testbench
=================================

// Module: spi_mem_bridge
// PURPOSE
//  SPI slave giving an external host burst read/write access to on-chip memory
//  (video RAM, registers). Generalises the fixed 16-bit-address, byte-data SPI memory
//  port: parametrised address/data width, SCK polarity, RAM read latency and
//  synchroniser depth. Adds explicit reset and a read shift register loaded from RAM.
//  Sits between the SPI pins and the memory arbiter, entirely in the clk domain.
// PARAMETERS
//  ADDR_W   16  header width; MSB = write flag, low ADDR_W-1 bits = start address
//  DATA_W   8   bits per data word, 4..32
//  CPOL     0   SCK idle level; CPHA fixed 0 (sample leading edge, shift trailing)
//  RD_LAT   1   clk cycles from re to valid data_r, 0..3
//  SYNC_N   3   synchroniser depth for sck/mosi/ssel_n, >=2
// PORTS
//  clk     in   1           system clock; must exceed 2*(SYNC_N+RD_LAT+2) x SCK
//  rst_n   in   1           async active-low reset
//  sck     in   1           SPI clock, async
//  mosi    in   1           SPI data in, MSB first
//  ssel_n  in   1           SPI select, active low
//  miso    out  1           SPI data out, MSB first
//  raddr   out  ADDR_W-1    read address, valid while re
//  re      out  1           one-clk read strobe
//  data_r  in   DATA_W      RAM read data, valid RD_LAT clks after re
//  waddr   out  ADDR_W-1    write address, valid while we
//  data_w  out  DATA_W      write data, valid while we
//  we      out  1           one-clk write strobe
//  busy    out  1           high while synchronised ssel_n is low
// BEHAVIOUR
//  - Reset: all outputs 0, miso 0, counters/shift registers 0, state IDLE.
//  - Edges: detected on the last two synchroniser stages; sample = sck rising when
//    CPOL=0, falling when CPOL=1; shift = the opposite edge.
//  - FSM: IDLE -> HDR on ssel_n fall; HDR -> DATA after ADDR_W sample edges; any state
//    -> IDLE on ssel_n rise, with no further re/we.
//  - HDR: shift mosi into hdr on each sample edge. On the ADDR_W-th edge latch
//    wr=hdr MSB and addr=low bits. If !wr, pulse re with raddr=addr on the next clk.
//  - DATA, write: shift DATA_W bits into data_w. On the clk after the DATA_W-th sample
//    edge, pulse we with waddr=addr, then addr<=addr+1.
//  - DATA, read: a word ends on the DATA_W-th sample edge; after each word end,
//    addr<=addr+1 and re pulses with the new raddr (prefetch). The word just finished
//    in DATA is never written.
//  - Read shift register: loads data_r exactly RD_LAT clks after re (RD_LAT=0 loads on
//    the re clk). miso = shift MSB. Shift edges move the register left one bit, except
//    the first shift edge after a load, which is skipped so the MSB is held for the
//    first sample edge of the next word.
//  - Address arithmetic: addr is ADDR_W-1 bits and wraps modulo 2^(ADDR_W-1);
//    e.g. 0x7FFF -> 0x0000 when ADDR_W=16.
//  - Partial word (ssel_n rises mid-word): discarded, no we. Incomplete header: no re.
//  - ssel_n fall while not IDLE (glitch re-select): forces HDR, clears counters.
//  - rst_n low mid-transfer: immediate return to reset values, no strobe completes.
//  - re and we are never high in the same clk; each is high at most 1 clk per word.
//  - miso is not tri-stated; board logic gates it with ssel_n.
// CONFIGURATION
//  SPI_XFER_CNT_EN defined: adds outputs xfer_words[15:0] (words completed in the
//    current/last transaction, saturating at 0xFFFF, cleared at HDR entry) and
//    xfer_done (1-clk pulse on ssel_n rise after HDR completed). The count is taken
//    on we for writes and on word end for reads.
//  Undefined: ports absent, no counter logic.
// TESTING
//  1 Reset: rst_n low mid-burst -> all outputs 0 next clk; no we/re afterwards.
//  2 Write burst: hdr 0x8010, data A5,3C, ssel_n high -> we x2: (0x0010,A5), (0x0011,3C).
//  3 Read burst: hdr 0x0200, RAM[0x200]=0x81, RAM[0x201]=0x7E, 16 data clocks ->
//    miso bytes 81,7E; re at addr 0x200, 0x201, 0x202.
//  4 Wrap: write hdr 0xFFFF, two bytes -> waddr 0x7FFF then 0x0000.
//  5 Abort: ssel_n rises after 5 data bits -> no we; next transaction decodes a
//    clean header.
//  6 Modes: repeat scenario 3 with CPOL=1, DATA_W=16, RD_LAT=2 -> identical words;
//    with SPI_XFER_CNT_EN, xfer_words=2 and one xfer_done pulse.

Source files
------------

// File: rtl/spi_mem_bridge_if.sv
// SPI pin bundle plus the memory read/write port of spi_mem_bridge.
// The bridge takes the slave view; the host/RAM side takes the master view.
interface spi_mem_bridge_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              sck;
    logic              mosi;
    logic              ssel_n;
    logic              miso;
    logic [ADDR_W-2:0] raddr;
    logic              re;
    logic [DATA_W-1:0] data_r;
    logic [ADDR_W-2:0] waddr;
    logic [DATA_W-1:0] data_w;
    logic              we;
    logic              busy;

    modport slave (
        input  sck, mosi, ssel_n, data_r,
        output miso, raddr, re, waddr, data_w, we, busy
    );

    modport master (
        output sck, mosi, ssel_n, data_r,
        input  miso, raddr, re, waddr, data_w, we, busy
    );
endinterface

// File: rtl/spi_mem_bridge.sv
// SPI slave (CPHA=0) giving a host burst read/write access to on-chip memory.
// Optional transfer word counter enabled by defining SPI_XFER_CNT_EN.
module spi_mem_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int RD_LAT = 1,
    parameter int SYNC_N = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_mem_bridge_if.slave  bus
`ifdef SPI_XFER_CNT_EN
    ,
    output logic [15:0]      xfer_words,
    output logic             xfer_done
`endif
);

    localparam int   MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int   CNT_W  = $clog2(MAX_W);
    localparam logic CPOL_L = (CPOL != 0);

    typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

    state_t            state, state_nxt;
    logic [SYNC_N-1:0] sck_sync, ssel_sync;
    logic [SYNC_N-2:0] mosi_sync;
    logic              sck_rise, sck_fall, ssel_rise, ssel_fall;
    logic              sample_edge, shift_edge, mosi_s;
    logic              hdr_done, word_done, cnt_clr, cnt_inc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [ADDR_W-2:0] hdr;
    logic [ADDR_W-2:0] hdr_addr, addr, addr_inc;
    logic              wr;
    logic [ADDR_W-2:0] raddr_q, waddr_q;
    logic [DATA_W-1:0] data_w_q, rd_shift;
    logic              re_q, we_q, skip, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_N{CPOL_L}};
            ssel_sync <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_N-2:0], bus.sck};
            ssel_sync <= {ssel_sync[SYNC_N-2:0], bus.ssel_n};
            mosi_sync <= (mosi_sync << 1) | (SYNC_N-1)'(bus.mosi);
        end
    end

    // Edges come from the two oldest synchroniser stages; mosi is taken from
    // the stage aligned with the newer sck sample.
    assign sck_rise    = sck_sync[SYNC_N-2] & ~sck_sync[SYNC_N-1];
    assign sck_fall    = ~sck_sync[SYNC_N-2] & sck_sync[SYNC_N-1];
    assign ssel_fall   = ~ssel_sync[SYNC_N-2] & ssel_sync[SYNC_N-1];
    assign ssel_rise   = ssel_sync[SYNC_N-2] & ~ssel_sync[SYNC_N-1];
    assign sample_edge = CPOL_L ? sck_fall : sck_rise;
    assign shift_edge  = CPOL_L ? sck_rise : sck_fall;
    assign mosi_s      = mosi_sync[SYNC_N-2];

    assign hdr_addr = {hdr[ADDR_W-3:0], mosi_s};
    assign addr_inc = addr + {{(ADDR_W-2){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_done  = 1'b0;
        word_done = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        if (ssel_fall) begin
            state_nxt = HDR;
            cnt_clr   = 1'b1;
        end else if (ssel_rise) begin
            state_nxt = IDLE;
            cnt_clr   = 1'b1;
        end else if (sample_edge) begin
            case (state)
                HDR: begin
                    if (bit_cnt == CNT_W'(ADDR_W-1)) begin
                        hdr_done  = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_W'(DATA_W-1)) begin
                        word_done = 1'b1;
                        cnt_clr   = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            hdr      <= '0;
            wr       <= 1'b0;
            addr     <= '0;
            data_w_q <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            re_q     <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            re_q <= 1'b0;
            we_q <= 1'b0;
            if (cnt_clr)      bit_cnt <= '0;
            else if (cnt_inc) bit_cnt <= bit_cnt + 1'b1;
            if (sample_edge && state == HDR)
                hdr <= {hdr[ADDR_W-3:0], mosi_s};
            if (sample_edge && state == DATA && wr)
                data_w_q <= {data_w_q[DATA_W-2:0], mosi_s};
            if (hdr_done) begin
                wr   <= hdr[ADDR_W-2];
                addr <= hdr_addr;
                if (!hdr[ADDR_W-2]) begin
                    re_q    <= 1'b1;
                    raddr_q <= hdr_addr;
                end
            end
            // A finished read word prefetches the next address; a finished
            // write word commits at the current address.
            if (word_done) begin
                addr <= addr_inc;
                if (wr) begin
                    we_q    <= 1'b1;
                    waddr_q <= addr;
                end else begin
                    re_q    <= 1'b1;
                    raddr_q <= addr_inc;
                end
            end
        end
    end

    generate
        if (RD_LAT == 0) begin : g_lat0
            assign load = re_q;
        end else begin : g_latn
            logic [RD_LAT-1:0] re_dly;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) re_dly <= '0;
                else        re_dly <= (re_dly << 1) | RD_LAT'(re_q);
            end
            assign load = re_dly[RD_LAT-1];
        end
    endgenerate

    // The first shift edge after a load is skipped so the MSB stays on miso
    // until the host samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_shift <= '0;
            skip     <= 1'b0;
        end else if (load) begin
            rd_shift <= bus.data_r;
            skip     <= 1'b1;
        end else if (shift_edge) begin
            if (skip) skip <= 1'b0;
            else      rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
        end
    end

`ifdef SPI_XFER_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_words <= '0;
            xfer_done  <= 1'b0;
        end else begin
            xfer_done <= ssel_rise && (state == DATA);
            if (ssel_fall)
                xfer_words <= '0;
            else if ((we_q || (word_done && !wr)) && xfer_words != 16'hFFFF)
                xfer_words <= xfer_words + 16'd1;
        end
    end
`endif

    assign bus.miso   = rd_shift[DATA_W-1];
    assign bus.raddr  = raddr_q;
    assign bus.re     = re_q;
    assign bus.waddr  = waddr_q;
    assign bus.data_w = data_w_q;
    assign bus.we     = we_q;
    assign bus.busy   = ~ssel_sync[SYNC_N-1];

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: default instance plus CPOL=1/16-bit/RD_LAT=2 instance.
module tb_spi_mem_bridge;

    localparam int HALF = 120;

    logic clk = 1'b0;
    logic rst_n;
    logic sck_l, mosi, ssel_a, ssel_b;

    int checks = 0;
    int errors = 0;
    int both0  = 0;
    int both1  = 0;
    int xd1_cnt = 0;

    logic [22:0] wq0[$];
    logic [14:0] rq0[$];
    logic [30:0] wq1[$];
    logic [14:0] rq1[$];

    logic [7:0]  ram0 [0:1023];
    logic [15:0] ram1 [0:1023];
    logic [15:0] d1;

    spi_mem_bridge_if #(.ADDR_W(16), .DATA_W(8))  if0();
    spi_mem_bridge_if #(.ADDR_W(16), .DATA_W(16)) if1();

`ifdef SPI_XFER_CNT_EN
    logic [15:0] xw0, xw1;
    logic        xd0, xd1;
`endif

    spi_mem_bridge #(.ADDR_W(16), .DATA_W(8), .CPOL(0), .RD_LAT(1), .SYNC_N(3)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
`ifdef SPI_XFER_CNT_EN
        , .xfer_words(xw0), .xfer_done(xd0)
`endif
    );

    spi_mem_bridge #(.ADDR_W(16), .DATA_W(16), .CPOL(1), .RD_LAT(2), .SYNC_N(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
`ifdef SPI_XFER_CNT_EN
        , .xfer_words(xw1), .xfer_done(xd1)
`endif
    );

    always #5 clk = ~clk;

    assign if0.sck    = sck_l;
    assign if0.mosi   = mosi;
    assign if0.ssel_n = ssel_a;
    assign if1.sck    = ~sck_l;
    assign if1.mosi   = mosi;
    assign if1.ssel_n = ssel_b;

    // RAM models: data valid exactly RD_LAT clocks after re, junk otherwise.
    always @(posedge clk) begin
        if0.data_r <= if0.re ? ram0[if0.raddr[9:0]] : 8'hEE;
        d1         <= if1.re ? ram1[if1.raddr[9:0]] : 16'hDEAD;
        if1.data_r <= d1;
    end

    always @(negedge clk) begin
        if (if0.we) wq0.push_back({if0.waddr, if0.data_w});
        if (if0.re) rq0.push_back(if0.raddr);
        if (if0.we && if0.re) both0++;
        if (if1.we) wq1.push_back({if1.waddr, if1.data_w});
        if (if1.re) rq1.push_back(if1.raddr);
        if (if1.we && if1.re) both1++;
`ifdef SPI_XFER_CNT_EN
        if (xd1) xd1_cnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wq0_at(input int i);
        return (i < wq0.size()) ? 32'(wq0[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rq0_at(input int i);
        return (i < rq0.size()) ? 32'(rq0[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rq1_at(input int i);
        return (i < rq1.size()) ? 32'(rq1[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic spi_bits(input int n, input logic [31:0] tx, input bit use_b,
                            output logic [31:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = tx[i];
            #(HALF);
            rx = {rx[30:0], (use_b ? if1.miso : if0.miso)};
            sck_l = 1'b1;
            #(HALF);
            sck_l = 1'b0;
        end
    endtask

    task automatic sel(input bit use_b, input logic lvl);
        if (use_b) ssel_b = lvl;
        else       ssel_a = lvl;
        #(2*HALF);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, " miso"},   32'(if0.miso),   0);
        chk({tag, " re"},     32'(if0.re),     0);
        chk({tag, " we"},     32'(if0.we),     0);
        chk({tag, " busy"},   32'(if0.busy),   0);
        chk({tag, " raddr"},  32'(if0.raddr),  0);
        chk({tag, " waddr"},  32'(if0.waddr),  0);
        chk({tag, " data_w"}, 32'(if0.data_w), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rx, rx2;
        for (int i = 0; i < 1024; i++) begin
            ram0[i] = 8'h00;
            ram1[i] = 16'h0000;
        end
        ram0[10'h200] = 8'h81;
        ram0[10'h201] = 8'h7E;
        ram1[10'h200] = 16'h817E;
        ram1[10'h201] = 16'h7E81;
        sck_l = 1'b0; mosi = 1'b0; ssel_a = 1'b1; ssel_b = 1'b1;
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        chk_zero0("rst0");
        chk("rst1 miso", 32'(if1.miso), 0);
        chk("rst1 busy", 32'(if1.busy), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write burst
        sel(0, 1'b0);
        chk("busy during sel", 32'(if0.busy), 1);
        spi_bits(16, 32'h8010, 0, rx);
        spi_bits(8, 32'hA5, 0, rx);
        spi_bits(8, 32'h3C, 0, rx);
        sel(0, 1'b1);
        chk("wr count", wq0.size(), 2);
        chk("wr word0", wq0_at(0), 32'h0000_10A5);
        chk("wr word1", wq0_at(1), 32'h0000_113C);
        chk("wr no re", rq0.size(), 0);
`ifdef SPI_XFER_CNT_EN
        chk("wr xfer_words", 32'(xw0), 2);
`endif
        wq0.delete(); rq0.delete();

        // Read burst
        sel(0, 1'b0);
        spi_bits(16, 32'h0200, 0, rx);
        spi_bits(8, 32'h00, 0, rx);
        spi_bits(8, 32'h00, 0, rx2);
        sel(0, 1'b1);
        chk("rd byte0", rx, 32'h81);
        chk("rd byte1", rx2, 32'h7E);
        chk("rd re count", rq0.size(), 3);
        chk("rd re0", rq0_at(0), 32'h200);
        chk("rd re1", rq0_at(1), 32'h201);
        chk("rd re2", rq0_at(2), 32'h202);
        chk("rd no we", wq0.size(), 0);
        wq0.delete(); rq0.delete();

        // Address wrap
        sel(0, 1'b0);
        spi_bits(16, 32'hFFFF, 0, rx);
        spi_bits(8, 32'h11, 0, rx);
        spi_bits(8, 32'h22, 0, rx);
        sel(0, 1'b1);
        chk("wrap count", wq0.size(), 2);
        chk("wrap word0", wq0_at(0), 32'h007F_FF11);
        chk("wrap word1", wq0_at(1), 32'h0000_0022);
        wq0.delete(); rq0.delete();

        // Abort mid-word, then a clean transaction
        sel(0, 1'b0);
        spi_bits(16, 32'h8040, 0, rx);
        spi_bits(5, 32'h1F, 0, rx);
        sel(0, 1'b1);
        chk("abort no we", wq0.size(), 0);
        sel(0, 1'b0);
        spi_bits(16, 32'h8050, 0, rx);
        spi_bits(8, 32'h5A, 0, rx);
        sel(0, 1'b1);
        chk("post-abort count", wq0.size(), 1);
        chk("post-abort word", wq0_at(0), 32'h0000_505A);
        chk("post-abort no re", rq0.size(), 0);
        wq0.delete(); rq0.delete();

        // Reset in the middle of a read burst
        sel(0, 1'b0);
        spi_bits(16, 32'h0200, 0, rx);
        spi_bits(4, 32'h0, 0, rx);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero0("midrst");
        wq0.delete(); rq0.delete();
        ssel_a = 1'b1;
        #(HALF);
        rst_n = 1'b1;
        spi_bits(8, 32'hFF, 0, rx);
        #(4*HALF);
        chk("midrst no we", wq0.size(), 0);
        chk("midrst no re", rq0.size(), 0);

        // CPOL=1, 16-bit words, RD_LAT=2
        sel(1, 1'b0);
        spi_bits(16, 32'h0200, 1, rx);
        spi_bits(16, 32'h0000, 1, rx);
        spi_bits(16, 32'h0000, 1, rx2);
        sel(1, 1'b1);
        chk("mode word0", rx, 32'h817E);
        chk("mode word1", rx2, 32'h7E81);
        chk("mode re count", rq1.size(), 3);
        chk("mode re0", rq1_at(0), 32'h200);
        chk("mode re1", rq1_at(1), 32'h201);
        chk("mode re2", rq1_at(2), 32'h202);
        chk("mode no we", wq1.size(), 0);
`ifdef SPI_XFER_CNT_EN
        chk("mode xfer_words", 32'(xw1), 2);
        chk("mode xfer_done", xd1_cnt, 1);
`endif
        chk("re/we excl dut0", both0, 0);
        chk("re/we excl dut1", both1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
